// File: rtl/uart_loader.sv
// Boot loader: pulls a framed memory image out of a polled UART, writes it word by word
// to memory while holding the CPU in reset, then answers with 'K' (ok) or 'E' (error).
module uart_loader #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 16384,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [2:0]  o_uart_address,
  output logic        o_uart_read,
  output logic        o_uart_write,
  output logic [31:0] o_uart_writedata,
  input  logic [31:0] i_uart_readdata,
  input  logic        i_uart_acknowledge,
  output logic [31:0] o_mem_address,
  output logic        o_mem_write,
  output logic [31:0] o_mem_writedata,
  input  logic        i_mem_acknowledge,
  output logic        o_cpu_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_word_count,
  output logic [2:0]  o_state
);

  // Handshake: a request (o_uart_read, o_uart_write or o_mem_write) is held until its
  // acknowledge is seen on a rising edge and drops on that edge; only one is ever high.
  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    MEMWR = 3'd3,
    CHECK = 3'd4,
    RESP  = 3'd5,
    IDLE  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] RESP_OK   = 8'h4B;
  localparam logic [7:0] RESP_ERR  = 8'h45;

  state_t      state, state_next;
  logic        read_gap;
  logic [1:0]  byte_index;
  logic [7:0]  checksum;
  logic [31:0] length;
  logic [31:0] word;
  logic [31:0] idle_count;
  logic        resp_ok;

  logic        reading;
  logic        byte_ok;
  logic        timed;
  logic        timeout;
  logic        last_word;
  logic [7:0]  rx_byte;
  logic [31:0] length_next;
  logic        unused_readdata;

  assign unused_readdata = ^{i_uart_readdata[31:16], i_uart_readdata[14:8]};

  // read_gap forces one idle cycle after every read acknowledge; it resets high so no
  // read is requested while reset is asserted.
  assign reading     = (state inside {HUNT, LEN, DATA, CHECK, IDLE}) && !read_gap;
  assign rx_byte     = i_uart_readdata[7:0];
  assign byte_ok     = reading && i_uart_acknowledge && i_uart_readdata[15];
  assign timed       = state inside {LEN, DATA, CHECK};
  assign timeout     = timed && !byte_ok && (idle_count >= 32'(TIMEOUT_CYCLES - 1));
  assign length_next = {rx_byte, length[31:8]};
  assign last_word   = (({16'h0000, o_word_count}) + 32'd1) == length;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= HUNT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT, IDLE: if (byte_ok && rx_byte == SYNC_BYTE) state_next = LEN;
      LEN: begin
        if (timeout) state_next = HUNT;
        else if (byte_ok && byte_index == 2'd3) begin
          if (length_next == 32'd0)                  state_next = CHECK;
          else if (length_next > 32'(MAX_WORDS))     state_next = RESP;
          else                                       state_next = DATA;
        end
      end
      DATA: begin
        if (timeout)                                 state_next = HUNT;
        else if (byte_ok && byte_index == 2'd3)      state_next = MEMWR;
      end
      MEMWR: if (i_mem_acknowledge) state_next = last_word ? CHECK : DATA;
      CHECK: begin
        if (timeout)      state_next = HUNT;
        else if (byte_ok) state_next = RESP;
      end
      RESP: if (i_uart_acknowledge) state_next = resp_ok ? IDLE : HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      read_gap     <= 1'b1;
      byte_index   <= 2'd0;
      checksum     <= 8'h00;
      length       <= 32'h0;
      word         <= 32'h0;
      idle_count   <= 32'h0;
      resp_ok      <= 1'b0;
      o_word_count <= 16'h0;
      o_cpu_reset  <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      read_gap   <= reading && i_uart_acknowledge;
      o_done     <= 1'b0;
      idle_count <= (!timed || byte_ok || i_mem_acknowledge) ? 32'h0 : idle_count + 32'd1;
      case (state)
        HUNT, IDLE: begin
          if (byte_ok && rx_byte == SYNC_BYTE) begin
            checksum     <= 8'h00;
            byte_index   <= 2'd0;
            o_word_count <= 16'h0;
            o_error      <= 1'b0;
            o_cpu_reset  <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        LEN: begin
          if (byte_ok) begin
            checksum   <= checksum + rx_byte;
            byte_index <= byte_index + 2'd1;
            length     <= length_next;
            if (byte_index == 2'd3 && length_next > 32'(MAX_WORDS)) resp_ok <= 1'b0;
          end
        end
        DATA: begin
          if (byte_ok) begin
            checksum   <= checksum + rx_byte;
            byte_index <= byte_index + 2'd1;
            word       <= {rx_byte, word[31:8]};
          end
        end
        MEMWR: if (i_mem_acknowledge) o_word_count <= o_word_count + 16'd1;
        CHECK: if (byte_ok) resp_ok <= (rx_byte == checksum);
        RESP: begin
          if (i_uart_acknowledge) begin
            o_busy <= 1'b0;
            if (resp_ok) begin
              o_done      <= 1'b1;
              o_cpu_reset <= 1'b0;
            end else begin
              o_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (timeout) begin
        o_error <= 1'b1;
        o_busy  <= 1'b0;
      end
    end
  end

  // Bus outputs decode straight from state so a reset drops any request at once.
  assign o_uart_address   = 3'd0;
  assign o_uart_read      = reading;
  assign o_uart_write     = (state == RESP);
  assign o_uart_writedata = o_uart_write ? {24'h0, (resp_ok ? RESP_OK : RESP_ERR)} : 32'h0;
  assign o_mem_write      = (state == MEMWR);
  assign o_mem_address    = o_mem_write ? BASE_ADDRESS + {14'h0, o_word_count, 2'b00} : 32'h0;
  assign o_mem_writedata  = o_mem_write ? word : 32'h0;
  assign o_state          = state;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: frame vectors from a table, plus hand-written
// sequences for slow UART/memory, inactivity timeout and reset during a memory write.
module tb_uart_loader;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [2:0]  o_uart_address;
  logic        o_uart_read;
  logic        o_uart_write;
  logic [31:0] o_uart_writedata;
  logic [31:0] i_uart_readdata = 32'h0;
  logic        i_uart_acknowledge = 1'b0;
  logic [31:0] o_mem_address;
  logic        o_mem_write;
  logic [31:0] o_mem_writedata;
  logic        i_mem_acknowledge = 1'b0;
  logic        o_cpu_reset;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_word_count;
  logic [2:0]  o_state;

  uart_loader #(
    .BASE_ADDRESS  (32'h0000_0000),
    .MAX_WORDS     (16384),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .o_uart_address    (o_uart_address),
    .o_uart_read       (o_uart_read),
    .o_uart_write      (o_uart_write),
    .o_uart_writedata  (o_uart_writedata),
    .i_uart_readdata   (i_uart_readdata),
    .i_uart_acknowledge(i_uart_acknowledge),
    .o_mem_address     (o_mem_address),
    .o_mem_write       (o_mem_write),
    .o_mem_writedata   (o_mem_writedata),
    .i_mem_acknowledge (i_mem_acknowledge),
    .o_cpu_reset       (o_cpu_reset),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_error           (o_error),
    .o_word_count      (o_word_count),
    .o_state           (o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clock = ~i_clock;

  // ---------------- models and scoreboard storage ----------------
  logic [7:0]  rx_q[$];
  logic [31:0] tx_q[$];
  logic [63:0] mem_q[$];
  logic [63:0] exp_q[$];
  int invalid_polls = 0;
  int mem_delay     = 0;
  int mem_wait      = 0;
  int viol          = 0;
  int done_cnt      = 0;
  int cyc           = 0;
  int last_pop_cyc  = 0;
  int checks        = 0;
  int errors        = 0;

  // UART and memory responders, driven on the falling edge.
  always @(negedge i_clock) begin
    cyc = cyc + 1;
    i_uart_acknowledge = 1'b0;
    i_mem_acknowledge  = 1'b0;
    i_uart_readdata    = 32'h0;
    if (i_reset) begin
      mem_wait = 0;
    end else begin
      if (o_uart_read) begin
        i_uart_acknowledge = 1'b1;
        if (invalid_polls > 0) begin
          invalid_polls = invalid_polls - 1;
          i_uart_readdata = 32'h0010_00EE;
        end else if (rx_q.size() > 0) begin
          i_uart_readdata = {8'h00, 8'h10, 1'b1, 7'h00, rx_q.pop_front()};
          last_pop_cyc = cyc;
        end
      end else if (o_uart_write) begin
        i_uart_acknowledge = 1'b1;
        tx_q.push_back(o_uart_writedata);
      end
      if (o_mem_write) begin
        if (mem_wait >= mem_delay) begin
          i_mem_acknowledge = 1'b1;
          mem_q.push_back({o_mem_address, o_mem_writedata});
          mem_wait = 0;
        end else begin
          mem_wait = mem_wait + 1;
        end
      end
      if ((int'(o_uart_read) + int'(o_uart_write) + int'(o_mem_write)) > 1) viol = viol + 1;
      if (o_done) done_cnt = done_cnt + 1;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0]     bytes;
    int               n;
    logic [7:0]       resp;
    int               nwr;
    logic [1:0][31:0] a;
    logic [1:0][31:0] d;
    logic             err;
    logic             cpu;
    int               ndone;
    logic [15:0]      cnt;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bytes(input logic [127:0] bytes, input int n);
    for (int i = 0; i < n; i++) rx_q.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_resp(input int tx_before, input string name);
    int k = 0;
    while (tx_q.size() <= tx_before && k < 3000) begin
      @(negedge i_clock);
      k++;
    end
    if (k >= 3000) check({name, "_resp_wait"}, 64'd0, 64'd1);
  endtask

  task automatic run_vec(input int vi, input string tag);
    int          tx_before   = tx_q.size();
    int          mem_before  = mem_q.size();
    int          done_before = done_cnt;
    logic [31:0] got;
    logic [63:0] got_wr;
    for (int i = 0; i < vecs[vi].nwr; i++) exp_q.push_back({vecs[vi].a[i], vecs[vi].d[i]});
    send_bytes(vecs[vi].bytes, vecs[vi].n);
    wait_resp(tx_before, tag);
    repeat (4) @(negedge i_clock);
    #1;
    got = (tx_q.size() > tx_before) ? tx_q[tx_before] : 32'hxxxx_xxxx;
    check({tag, "_resp"}, 64'(got), 64'({24'h0, vecs[vi].resp}));
    check({tag, "_resp_count"}, 64'(tx_q.size() - tx_before), 64'd1);
    check({tag, "_nwr"}, 64'(mem_q.size() - mem_before), 64'(vecs[vi].nwr));
    for (int i = 0; i < vecs[vi].nwr; i++) begin
      got_wr = (mem_before + i < mem_q.size()) ? mem_q[mem_before + i] : 64'hx;
      check($sformatf("%s_wr%0d", tag, i), got_wr, exp_q.pop_front());
    end
    check({tag, "_done"}, 64'(done_cnt - done_before), 64'(vecs[vi].ndone));
    check({tag, "_error"}, 64'(o_error), 64'(vecs[vi].err));
    check({tag, "_cpu_reset"}, 64'(o_cpu_reset), 64'(vecs[vi].cpu));
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_word_count"}, 64'(o_word_count), 64'(vecs[vi].cnt));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    int mem_before;
    int tx_before;

    // Checksums: 01+78+56+34+12 = 15; 02+11+22+33+44+AA+BB+CC+DD = BA (mod 256).
    vecs[0] = '{bytes: 128'hA5_01000000_78563412_15, n: 10, resp: 8'h4B, nwr: 1,
                a: {32'h0, 32'h0}, d: {32'h0, 32'h1234_5678},
                err: 1'b0, cpu: 1'b0, ndone: 1, cnt: 16'd1};
    vecs[1] = '{bytes: 128'hA5_01000000_78563412_16, n: 10, resp: 8'h45, nwr: 1,
                a: {32'h0, 32'h0}, d: {32'h0, 32'h1234_5678},
                err: 1'b1, cpu: 1'b1, ndone: 0, cnt: 16'd1};
    vecs[2] = '{bytes: 128'h00FF5A_A5_00000000_00, n: 9, resp: 8'h4B, nwr: 0,
                a: {32'h0, 32'h0}, d: {32'h0, 32'h0},
                err: 1'b0, cpu: 1'b0, ndone: 1, cnt: 16'd0};
    vecs[3] = '{bytes: 128'hA5_01400000, n: 5, resp: 8'h45, nwr: 0,
                a: {32'h0, 32'h0}, d: {32'h0, 32'h0},
                err: 1'b1, cpu: 1'b1, ndone: 0, cnt: 16'd0};
    vecs[4] = '{bytes: 128'hA5_02000000_11223344_AABBCCDD_BA, n: 14, resp: 8'h4B, nwr: 2,
                a: {32'h4, 32'h0}, d: {32'hDDCC_BBAA, 32'h4433_2211},
                err: 1'b0, cpu: 1'b0, ndone: 1, cnt: 16'd2};

    // Reset state.
    repeat (3) @(negedge i_clock);
    #1;
    check("rst_cpu_reset", 64'(o_cpu_reset), 64'd1);
    check("rst_outputs", 64'({o_uart_read, o_uart_write, o_mem_write, o_busy, o_done, o_error}), 64'd0);
    check("rst_buses", {o_uart_writedata, o_mem_address}, 64'd0);
    check("rst_count_state", 64'({o_word_count, o_state}), 64'd0);
    @(negedge i_clock);
    i_reset = 1'b0;

    for (int v = 0; v < 5; v++) run_vec(v, $sformatf("v%0d", v));

    // Slow UART (10 empty polls) and slow memory (5 cycle acknowledge).
    invalid_polls = 10;
    mem_delay     = 5;
    run_vec(4, "slow");
    check("slow_polls_used", 64'(invalid_polls), 64'd0);
    check("single_outstanding", 64'(viol), 64'd0);
    mem_delay = 0;

    // Frame stalls after two data bytes: error exactly 100 edges after the last byte.
    tx_before  = tx_q.size();
    mem_before = mem_q.size();
    send_bytes(128'hA5_04000000_1122, 7);
    k = 0;
    while (!o_error && k < 500) begin
      @(negedge i_clock);
      #1;
      k++;
    end
    check("to_seen", 64'(o_error), 64'd1);
    check("to_latency", 64'(cyc - last_pop_cyc), 64'd101);
    check("to_state_hunt", 64'(o_state), 64'd0);
    check("to_busy", 64'(o_busy), 64'd0);
    check("to_cpu_reset", 64'(o_cpu_reset), 64'd1);
    check("to_no_tx", 64'(tx_q.size() - tx_before), 64'd0);
    check("to_no_mem", 64'(mem_q.size() - mem_before), 64'd0);

    // Reset while a memory write is waiting for its acknowledge.
    mem_delay  = 1000;
    mem_before = mem_q.size();
    send_bytes(128'hA5_01000000_01020304_0A, 10);
    k = 0;
    while (!o_mem_write && k < 500) begin
      @(negedge i_clock);
      #1;
      k++;
    end
    check("mrst_memwr_reached", 64'(o_mem_write), 64'd1);
    i_reset = 1'b1;
    #1;
    check("mrst_write_drops", 64'(o_mem_write), 64'd0);
    rx_q.delete();
    mem_delay = 0;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clock);
    #1;
    check("mrst_no_write", 64'(mem_q.size() - mem_before), 64'd0);
    check("mrst_cpu_reset", 64'(o_cpu_reset), 64'd1);
    check("mrst_idle_outputs", 64'({o_busy, o_error, o_state}), 64'd0);

    // Recovery after the abandoned frame.
    run_vec(0, "recover");
    check("final_single_outstanding", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h0000_0000, byte address of first loaded word.
REQ-002 Parameter MAX_WORDS, default 16384, largest accepted image length in 32-bit words.
REQ-003 Parameter TIMEOUT_CYCLES, default 50_000_000, maximum idle clocks between received bytes once a frame has started.
REQ-004 i_clock  in  1  sole clock; all logic on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 o_uart_address  out  3  UART register address: 0 = RX pop / TX push, 4 = TX space.
REQ-007 o_uart_read / o_uart_write  out  1 each  UART bus requests.
REQ-008 o_uart_writedata  out  32  response byte in [7:0], upper bits zero.
REQ-009 i_uart_readdata  in  32  [7:0] byte, [15] byte valid, [23:16] space/count field.
REQ-010 i_uart_acknowledge  in  1  UART transfer complete.
REQ-011 o_mem_address  out  32  memory byte address.
REQ-012 o_mem_write  out  1  memory write request.
REQ-013 o_mem_writedata  out  32  assembled word.
REQ-014 i_mem_acknowledge  in  1  memory write complete.
REQ-015 o_cpu_reset  out  1  holds the CPU in reset while loading.
REQ-016 o_busy / o_done / o_error  out  1 each  frame active / one-cycle success pulse / sticky failure.
REQ-017 o_word_count  out  16  words written in the current frame.

Function
REQ-018 Frame format: sync 8'hA5; 4-byte word count N, little-endian; 4*N data bytes, each word little-endian; one checksum byte.
REQ-019 Checksum: 8-bit wrap-around sum of all length and data bytes, excluding sync and checksum bytes.
REQ-020 Byte fetch: assert o_uart_read with address 0, hold until i_uart_acknowledge = 1, deassert on that edge; byte is taken only if i_uart_readdata[15] = 1, otherwise re-poll on the next cycle.
REQ-021 UART and memory requests are mutually exclusive; at most one request is outstanding at any time.
REQ-022 States: HUNT, LEN, DATA, MEMWR, CHECK, RESP, IDLE.
REQ-023 HUNT: consume bytes; bytes other than A5 are discarded; on A5 clear checksum, byte index and o_word_count, clear o_error, set o_cpu_reset and o_busy, go to LEN.
REQ-024 LEN: after the 4th byte go to DATA if 0 < N <= MAX_WORDS, to CHECK if N = 0, and to RESP with error if N > MAX_WORDS.
REQ-025 DATA: after every 4th byte go to MEMWR; no UART reads occur while in MEMWR.
REQ-026 MEMWR: o_mem_address = BASE_ADDRESS + 4*o_word_count (32-bit wrap).
REQ-027 MEMWR: hold o_mem_write until i_mem_acknowledge; on acknowledge increment o_word_count, then return to DATA, or go to CHECK when the count equals N.
REQ-028 CHECK: read one byte; a match gives success, a mismatch gives error.
REQ-029 RESP: write 8'h4B on success or 8'h45 on error to address 0; hold o_uart_write until acknowledge.
REQ-030 After RESP on success: pulse o_done for one cycle, deassert o_cpu_reset, go to IDLE.
REQ-031 After RESP on error: set o_error, keep o_cpu_reset high, go to HUNT.
REQ-032 IDLE: poll bytes as in HUNT; a received A5 starts a new frame per REQ-023.
REQ-033 Timeout: a counter resets on every accepted byte and on memory acknowledge.
REQ-034 Timeout: in LEN, DATA or CHECK, reaching TIMEOUT_CYCLES sets o_error, deasserts o_busy and returns to HUNT with no response byte.
REQ-035 o_busy is high from sync acceptance until exit from RESP or timeout.

Reset
REQ-036 While i_reset is high: state HUNT, o_cpu_reset = 1, all other outputs 0, checksum/index/timeout counters 0.
REQ-037 Reset applied mid-operation abandons any outstanding request immediately; no partial word is written after reset.

Verification
REQ-038 A5, 01 00 00 00, 78 56 34 12, checksum 15 -> one memory write of 0x12345678 to 0x0, UART write 0x4B, o_done pulse, o_cpu_reset falls.
REQ-039 Same frame with checksum 16 -> word still written, UART write 0x45, o_error = 1, o_cpu_reset stays 1.
REQ-040 Garbage 00 FF 5A, then A5, 00 00 00 00, checksum 00 -> garbage ignored, no memory writes, response 0x4B.
REQ-041 Length 01 40 00 00 with MAX_WORDS = 16384 -> response 0x45 right after the length, no memory writes.
REQ-042 i_uart_readdata[15] = 0 for 10 polls, then valid bytes; i_mem_acknowledge delayed 5 cycles -> correct image, single outstanding request throughout.
REQ-043 TIMEOUT_CYCLES = 100, frame stalls after 2 data bytes -> o_error at cycle 100, HUNT, no UART write; i_reset mid-MEMWR -> o_mem_write drops immediately.
